// File: rtl/seg_scan_driver.sv
// Eight-digit 7-segment scan driver: one shared segment bus, one-hot digit enables, per-slot blanking guard.
// Optional per-direction blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] n_msb,
  input  logic [6:0] n_lsb,
  input  logic [6:0] e_msb,
  input  logic [6:0] e_lsb,
  input  logic [6:0] s_msb,
  input  logic [6:0] s_lsb,
  input  logic [6:0] w_msb,
  input  logic [6:0] w_lsb,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [3:0] blink_mask,
`endif
  output logic [6:0] seg_out,
  output logic [7:0] an_out,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [7:0] AN_OFF  = (AN_ACT_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  // Elaboration-time guard against an unusable configuration.
  if (TICK_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= TICK_DIV || BLINK_FRAMES < 1) begin : g_bad_cfg
    $error("seg_scan_driver: illegal TICK_DIV/BLANK_CYCLES/BLINK_FRAMES");
  end

  function automatic logic [6:0] pick_digit(input logic [2:0] idx, input logic [55:0] pats);
    return pats[32'(idx) * 7 +: 7];
  endfunction

  function automatic logic [6:0] seg_drive(input logic [6:0] lit);
    return (SEG_ACT_LOW != 0) ? ~lit : lit;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_p, w_p_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [6:0]      r_latch, w_latch_nxt;
  logic            w_frame_nxt;
  logic [6:0]      w_seg_nxt;
  logic [7:0]      w_an_nxt;
  logic [55:0]     w_pats;
  logic            w_blink_off;

  assign w_pats    = {w_lsb, w_msb, s_lsb, s_msb, e_lsb, e_msb, n_lsb, n_msb};
  assign digit_idx = r_idx;

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_fcnt, w_fcnt_nxt;
  logic          r_phase, w_phase_nxt;

  // Frame counter and blink phase; both cleared whenever the scan goes idle.
  always_comb begin
    w_fcnt_nxt  = r_fcnt;
    w_phase_nxt = r_phase;
    if (w_state_nxt == S_IDLE) begin
      w_fcnt_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (w_frame_nxt) begin
      if (r_fcnt == F_LAST) begin
        w_fcnt_nxt  = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_fcnt_nxt  = r_fcnt + FW'(1);
      end
    end else begin
      w_fcnt_nxt  = r_fcnt;
    end
    w_blink_off = w_phase_nxt & blink_mask[w_idx_nxt[2:1]];
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_fcnt  <= w_fcnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end
`else
  assign w_blink_off = 1'b0;
`endif

  // Next-state, prescaler, slot index and pattern latch.
  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_idx_nxt   = r_idx;
    w_latch_nxt = r_latch;
    w_frame_nxt = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_p_nxt     = '0;
      w_idx_nxt   = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_p_nxt     = '0;
          w_idx_nxt   = 3'd0;
          w_latch_nxt = pick_digit(3'd0, w_pats);
        end
        S_BLANK, S_DRIVE: begin
          if (r_p == P_LAST) begin
            w_p_nxt     = '0;
            w_idx_nxt   = r_idx + 3'd1;
            w_latch_nxt = pick_digit(r_idx + 3'd1, w_pats);
            w_frame_nxt = (r_idx == 3'd7);
          end else begin
            w_p_nxt     = r_p + PW'(1);
          end
        end
        default: begin
          w_p_nxt     = '0;
          w_idx_nxt   = 3'd0;
        end
      endcase
      w_state_nxt = (w_p_nxt < P_BLANK) ? S_BLANK : S_DRIVE;
    end
  end

  // Pin values are derived from the next-cycle state so they line up with the registered p/digit_idx.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_an_nxt  = AN_OFF;
    if (w_state_nxt == S_DRIVE) begin
      w_an_nxt  = AN_OFF ^ (8'h01 << w_idx_nxt);
      w_seg_nxt = w_blink_off ? SEG_OFF : seg_drive(w_latch_nxt);
    end else begin
      w_an_nxt  = AN_OFF;
      w_seg_nxt = SEG_OFF;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_p        <= '0;
      r_idx      <= 3'd0;
      r_latch    <= 7'h00;
      seg_out    <= SEG_OFF;
      an_out     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_p        <= w_p_nxt;
      r_idx      <= w_idx_nxt;
      r_latch    <= w_latch_nxt;
      seg_out    <= w_seg_nxt;
      an_out     <= w_an_nxt;
      frame_done <= w_frame_nxt;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexes the eight 7-segment countdown digits (N/E/S/W, msb/lsb) onto one shared segment bus and eight digit-enable lines of the physical board display.
- Sits directly downstream of the four seven-segment encoders; its outputs go straight to the board pins.
- Uses slot-based scanning with a blanking guard at the start of each slot to suppress ghosting.
- Latches each digit's pattern at slot start, so mid-slot input changes never tear the displayed digit.

Parameters:
- TICK_DIV, 50000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; must be < TICK_DIV; 0 disables blanking.
- SEG_ACT_LOW, 1, 1 = seg_out driven active-low, 0 = active-high.
- AN_ACT_LOW, 1, 1 = an_out driven active-low, 0 = active-high.
- BLINK_FRAMES, 64, full frames per blink half-period; used only with SEG_SCAN_BLINK_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  scan enable; 0 forces the display dark and the scan idle.
- n_msb, n_lsb, e_msb, e_lsb, s_msb, s_lsb, w_msb, w_lsb  in  7 each  segment patterns, bit=1 means segment lit.
- blink_mask  in  4  per-direction blink request, bit0=N, bit1=E, bit2=S, bit3=W; present only with SEG_SCAN_BLINK_EN.
- seg_out  out  7  shared segment bus, polarity per SEG_ACT_LOW.
- an_out  out  8  digit enables, one-hot when driving, polarity per AN_ACT_LOW.
- digit_idx  out  3  current slot index.
- frame_done  out  1  one-cycle pulse at each 7→0 wrap.

Behaviour:
- Slot order: 0 n_msb, 1 n_lsb, 2 e_msb, 3 e_lsb, 4 s_msb, 5 s_lsb, 6 w_msb, 7 w_lsb.
- States:
  - IDLE: enable=0.
  - BLANK: prescaler p < BLANK_CYCLES.
  - DRIVE: p ≥ BLANK_CYCLES.
- Transitions:
  - IDLE→BLANK on the edge where enable=1 (→DRIVE directly if BLANK_CYCLES=0).
  - BLANK→DRIVE when p reaches BLANK_CYCLES.
  - DRIVE→BLANK on slot wrap.
  - Any state→IDLE on the edge where enable=0.
- Prescaler: each enabled edge, p ← (p==TICK_DIV-1) ? 0 : p+1. On wrap, digit_idx ← digit_idx+1 (mod 8).
- Pattern latch: the pattern for digit d is captured into seg_latch on the edge that starts slot d (p becomes 0). Input changes within the slot are ignored until the next visit.
- All outputs are flops whose values correspond to the registered p and digit_idx of the same cycle. No combinational path from inputs to pins.
  - BLANK/IDLE: an_out all off, seg_out all off.
  - DRIVE: an_out bit digit_idx on, seg_out = seg_latch.
  - Polarity: "on/lit" = 0 when the corresponding *_ACT_LOW = 1.
- frame_done: high exactly one cycle, the first cycle of slot 0 following slot 7. Not asserted on the first slot 0 after IDLE/reset.
- Reset (reset=0 at edge): p=0, digit_idx=0, state IDLE, seg_latch=0, seg_out=all-off (7'h7F when SEG_ACT_LOW=1), an_out=all-off (8'hFF when AN_ACT_LOW=1), frame_done=0. Reset overrides enable.
- enable dropped mid-slot: next cycle outputs dark, p=0, digit_idx=0. Re-enable always restarts at slot 0, BLANK.
- Simultaneous reset=0 and enable=1: reset wins.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- When defined:
  - blink_mask port exists.
  - Internal frame counter toggles blink_phase every BLINK_FRAMES frame_done pulses; blink_phase resets to 0 and clears in IDLE.
  - While blink_phase=1, digits of each direction whose mask bit is 1 show seg_out all-off during DRIVE; an_out is still asserted.
- When undefined: port absent, no counter, all digits always driven.

Test Plan:
- Reset then enable=1 with TICK_DIV=8, BLANK_CYCLES=2, all *_ACT_LOW=1 → cycles 0–1: an_out=8'hFF, seg_out=7'h7F; cycles 2–7: an_out=8'hFE, seg_out=~n_msb; cycle 8: digit_idx=1 and blank.
- Full frame → an_out one-hot low walks bits 0..7 in slot order; frame_done high exactly one cycle at cycle 64; no pulse at cycle 0.
- Change n_lsb from 7'h06 to 7'h5B at cycle 12 (mid slot 1) → slot 1 still shows ~7'h06; next visit (cycle 72) shows ~7'h5B.
- Drop enable at cycle 20, raise at 25 → cycle 21 onward dark with digit_idx=0; restart at slot 0 BLANK; no frame_done on restart.
- Assert reset=0 mid-DRIVE → next edge: seg_out=7'h7F, an_out=8'hFF, digit_idx=0, frame_done=0, despite enable=1.
- SEG_SCAN_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0100 → after 2 frames, slots 4–5 show seg_out=7'h7F with an_out low; slots 0–3 and 6–7 unaffected; after 2 more frames, S digits are driven again.
